// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard and forwarding controller for the 5-stage RISC-V pipeline.
// It keeps its own copy of the rd / Reg_Write / Mem_Read control that travels
// down ID/EX, EX/MEM and MEM/WB. From that copy it derives the EX operand
// forward selects, the load-use stall, the redirect flush and the freeze
// applied while data memory is not ready.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_rs1_i/rs2_i    source registers of the instruction in ID
//   id_use_rs1/2_i    ID instruction actually reads rs1 / rs2
//   id_rd_i           destination register of the instruction in ID
//   id_reg_write_i    ID instruction writes rd
//   id_mem_read_i     ID instruction is a load
//   ex_redirect_i     EX resolved a taken branch / JAL / JALR this cycle
//   mem_wait_i        data memory not ready, freeze the whole pipe
//   pc_write_o        PC update enable
//   if_id_write_o     IF/ID register enable
//   if_id_flush_o     IF/ID loads a NOP
//   id_ex_bubble_o    ID/EX loads zero control
//   fwd_a_o/fwd_b_o   EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   state_o           FSM state: 00 RUN, 01 LDSTALL, 10 REDIR
//
// Optional feature (macro HAZARD_PERF_EN):
//   stall_cnt_o       saturating count of load-use bubble cycles
//   flush_cnt_o       saturating count of IF/ID flush cycles
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_wait_i,
    output logic                  pc_write_o,
    output logic                  if_id_write_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_REDIR   = 2'b10
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;

    // Shadow copy of the pipeline control fields
    logic [REG_ADDR_W-1:0]   ex_rs1_r;
    logic [REG_ADDR_W-1:0]   ex_rs2_r;
    logic [REG_ADDR_W-1:0]   ex_rd_r;
    logic                    ex_reg_write_r;
    logic                    ex_mem_read_r;
    logic [REG_ADDR_W-1:0]   mem_rd_r;
    logic                    mem_reg_write_r;
    logic [REG_ADDR_W-1:0]   wb_rd_r;
    logic                    wb_reg_write_r;

    logic                    load_use_s;
    logic                    pc_write_s;
    logic                    if_id_write_s;
    logic                    if_id_flush_s;
    logic                    id_ex_bubble_s;
    logic [1:0]              fwd_a_s;
    logic [1:0]              fwd_b_s;

    // Forward select for one EX operand; the younger EX/MEM result wins and
    // x0 is never forwarded because it is hardwired to zero.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        logic [1:0] sel;
        if (m_we && (m_rd != '0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load in EX whose destination is needed by the instruction in ID
    always_comb begin
        load_use_s = ex_mem_read_r && (ex_rd_r != '0) &&
                     ((id_use_rs1_i && (ex_rd_r == id_rs1_i)) ||
                      (id_use_rs2_i && (ex_rd_r == id_rs2_i)));
    end

    // Operand forward selects from the shadow pipe
    always_comb begin
        fwd_a_s = fwd_sel(ex_rs1_r, mem_rd_r, mem_reg_write_r, wb_rd_r, wb_reg_write_r);
        fwd_b_s = fwd_sel(ex_rs2_r, mem_rd_r, mem_reg_write_r, wb_rd_r, wb_reg_write_r);
    end

    // Pipe enables: freeze > redirect > load-use stall > free run.
    // Load-use is only honoured in RUN; in REDIR the ID slot holds a squashed
    // NOP, and in LDSTALL the bubble is already in EX.
    always_comb begin
        pc_write_s     = 1'b1;
        if_id_write_s  = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        if (mem_wait_i) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
        end else if (ex_redirect_i) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else if ((state_r == ST_RUN) && load_use_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else begin
            pc_write_s     = 1'b1;
            if_id_write_s  = 1'b1;
        end
    end

    // Next-state logic; the state holds while memory is stalled
    always_comb begin
        state_next_s = state_r;
        if (mem_wait_i) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (ex_redirect_i) begin
                        state_next_s = ST_REDIR;
                    end else if (load_use_s) begin
                        state_next_s = ST_LDSTALL;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_LDSTALL: begin
                    if (ex_redirect_i) begin
                        state_next_s = ST_REDIR;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_REDIR: begin
                    state_next_s = ST_RUN;
                end
                default: begin
                    state_next_s = ST_RUN;
                end
            endcase
        end
    end

    // State register and shadow pipe; a bubble zeroes the EX entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_RUN;
            ex_rs1_r        <= '0;
            ex_rs2_r        <= '0;
            ex_rd_r         <= '0;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            mem_rd_r        <= '0;
            mem_reg_write_r <= 1'b0;
            wb_rd_r         <= '0;
            wb_reg_write_r  <= 1'b0;
        end else if (!mem_wait_i) begin
            state_r         <= state_next_s;
            if (id_ex_bubble_s) begin
                ex_rs1_r       <= '0;
                ex_rs2_r       <= '0;
                ex_rd_r        <= '0;
                ex_reg_write_r <= 1'b0;
                ex_mem_read_r  <= 1'b0;
            end else begin
                ex_rs1_r       <= id_rs1_i;
                ex_rs2_r       <= id_rs2_i;
                ex_rd_r        <= id_rd_i;
                ex_reg_write_r <= id_reg_write_i;
                ex_mem_read_r  <= id_mem_read_i;
            end
            mem_rd_r        <= ex_rd_r;
            mem_reg_write_r <= ex_reg_write_r;
            wb_rd_r         <= mem_rd_r;
            wb_reg_write_r  <= mem_reg_write_r;
        end else begin
            state_r         <= state_r;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        stall_inc_s;

    // A bubble without a redirect can only come from load-use
    always_comb begin
        stall_inc_s = id_ex_bubble_s && !ex_redirect_i;
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_inc_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (if_id_flush_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;
`endif

    assign pc_write_o     = pc_write_s;
    assign if_id_write_o  = if_id_write_s;
    assign if_id_flush_o  = if_id_flush_s;
    assign id_ex_bubble_o = id_ex_bubble_s;
    assign fwd_a_o        = fwd_a_s;
    assign fwd_b_o        = fwd_b_s;
    assign state_o        = state_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Cycle-by-cycle vector table for hazard_forward_unit. Each record gives the
// ID-stage control plus redirect / wait / reset for one cycle and the hand
// computed enables, forward selects and state expected in that cycle.
// Inputs change on the falling edge and outputs are sampled 2 time units
// before the next rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_redirect;
    logic       mem_wait;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    hazard_forward_unit #(.REG_ADDR_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .id_rd_i        (id_rd),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .ex_redirect_i  (ex_redirect),
        .mem_wait_i     (mem_wait),
        .pc_write_o     (pc_write),
        .if_id_write_o  (if_id_write),
        .if_id_flush_o  (if_id_flush),
        .id_ex_bubble_o (id_ex_bubble),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .state_o        (state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       redir;
        logic       mw;
        logic [9:0] exp;   // {pc_write, if_id_write, flush, bubble, fwd_a, fwd_b, state}
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    // Enable groups {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] NORM  = 4'b1100;
    localparam logic [3:0] STALL = 4'b0001;
    localparam logic [3:0] RDIR  = 4'b1111;
    localparam logic [3:0] FRZ   = 4'b0000;

    task automatic av(input string n, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic rdr, input logic mw,
                      input logic [3:0] en, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [1:0] st);
        vec_t v;
        v.name = n; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.mr = mr; v.redir = rdr; v.mw = mw;
        v.exp = {en, fa, fb, st};
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %b expected %b", n, got, exp);
        end
    endtask

    initial begin
        logic [9:0] got;
        n_pass  = 0;
        n_total = 0;

        //  name                     rst rs1 rs2 u1 u2 rd  rw mr rdr mw  enables fwd_a  fwd_b  state
        av("reset_state",            0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("lw5_enter",              0, 1, 0, 1, 0, 5,  1, 1, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("load_use_stall",         0, 5, 2, 1, 1, 6,  1, 0, 0, 0, STALL, 2'b00, 2'b00, 2'b00);
        av("ldstall_release",        0, 5, 2, 1, 1, 6,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b01);
        av("fwd_a_memwb",            0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b01, 2'b00, 2'b00);
        av("x7a_enter",              0, 0, 0, 1, 0, 7,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("x7b_enter",              0, 3, 0, 1, 0, 7,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("x7_reader_enter",        0, 6, 7, 1, 1, 8,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("fwd_b_exmem_wins",       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b10, 2'b00);
        av("x0_write_a",             0, 0, 0, 0, 0, 0,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("x0_write_b",             0, 0, 0, 0, 0, 0,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("x0_not_forwarded",       0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("lw_x0_enter",            0, 1, 0, 1, 0, 0,  1, 1, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("lw_x0_no_stall",         0, 0, 0, 1, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("lw9_enter",              0, 2, 0, 1, 0, 9,  1, 1, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("redirect_beats_loaduse", 0, 9, 0, 1, 0, 10, 1, 0, 1, 0, RDIR,  2'b00, 2'b00, 2'b00);
        av("redir_state",            0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b10);
        av("redir_back_to_run",      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("lw5_enter_w",            0, 1, 0, 1, 0, 5,  1, 1, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("stall_before_wait",      0, 5, 0, 1, 0, 6,  1, 0, 0, 0, STALL, 2'b00, 2'b00, 2'b00);
        av("wait_in_ldstall_1",      0, 5, 0, 1, 0, 6,  1, 0, 0, 1, FRZ,   2'b00, 2'b00, 2'b01);
        av("wait_in_ldstall_2",      0, 5, 0, 1, 0, 6,  1, 0, 0, 1, FRZ,   2'b00, 2'b00, 2'b01);
        av("wait_in_ldstall_3",      0, 5, 0, 1, 0, 6,  1, 0, 0, 1, FRZ,   2'b00, 2'b00, 2'b01);
        av("ldstall_after_wait",     0, 5, 0, 1, 0, 6,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b01);
        av("wait_holds_fwd",         0, 0, 0, 0, 0, 0,  0, 0, 0, 1, FRZ,   2'b01, 2'b00, 2'b00);
        av("fwd_after_wait",         0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b01, 2'b00, 2'b00);
        av("idle_after_wait",        0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("lw5_enter_r",            0, 1, 0, 1, 0, 5,  1, 1, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("stall_before_reset",     0, 5, 0, 1, 0, 6,  1, 0, 0, 0, STALL, 2'b00, 2'b00, 2'b00);
        av("reset_in_ldstall",       1, 5, 0, 1, 0, 6,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b01);
        av("after_reset_ldstall",    0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("redirect_before_reset",  0, 0, 0, 0, 0, 0,  0, 0, 1, 0, RDIR,  2'b00, 2'b00, 2'b00);
        av("reset_in_redir",         1, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b10);
        av("after_reset_redir",      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("b2b_lw5_enter",          0, 0, 0, 0, 0, 5,  1, 1, 0, 0, NORM,  2'b00, 2'b00, 2'b00);
        av("b2b_first_stall",        0, 5, 0, 1, 0, 6,  1, 1, 0, 0, STALL, 2'b00, 2'b00, 2'b00);
        av("b2b_first_release",      0, 5, 0, 1, 0, 6,  1, 1, 0, 0, NORM,  2'b00, 2'b00, 2'b01);
        av("b2b_second_stall",       0, 6, 0, 1, 0, 7,  1, 0, 0, 0, STALL, 2'b01, 2'b00, 2'b00);
        av("b2b_second_release",     0, 6, 0, 1, 0, 7,  1, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b01);
        av("b2b_fwd",                0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b01, 2'b00, 2'b00);
        av("redirect_in_run",        0, 0, 0, 0, 0, 0,  0, 0, 1, 0, RDIR,  2'b00, 2'b00, 2'b00);
        av("redirect_in_redir",      0, 0, 0, 0, 0, 0,  0, 0, 1, 0, RDIR,  2'b00, 2'b00, 2'b10);
        av("final_idle",             0, 0, 0, 0, 0, 0,  0, 0, 0, 0, NORM,  2'b00, 2'b00, 2'b00);

        // Initial reset with the ID slot idle
        reset = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        ex_redirect = 1'b0; mem_wait = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset        = vecs[i].rst;
            id_rs1       = vecs[i].rs1;
            id_rs2       = vecs[i].rs2;
            id_use_rs1   = vecs[i].u1;
            id_use_rs2   = vecs[i].u2;
            id_rd        = vecs[i].rd;
            id_reg_write = vecs[i].rw;
            id_mem_read  = vecs[i].mr;
            ex_redirect  = vecs[i].redir;
            mem_wait     = vecs[i].mw;
            #3;
            got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b, state};
            check(vecs[i].name, {22'd0, got}, {22'd0, vecs[i].exp});
        end

`ifdef HAZARD_PERF_EN
        // Since the last reset: two load-use stalls and two redirect flushes
        check("stall_cnt", stall_cnt, 32'd2);
        check("flush_cnt", flush_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
